param_fifo: RTL and testbench
=============================

PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 16, storage entries (>=2); non-power-of-two values SHALL be supported.
REQ-003 Parameter AF_LEVEL, default 14, almost-full threshold in entries (1..DEPTH).
REQ-004 Parameter AE_LEVEL, default 2, almost-empty threshold in entries (0..DEPTH-1).
REQ-005 CW = clog2(DEPTH+1); all occupancy outputs SHALL be CW bits.
REQ-006 clk  in  1  clock; all state updates on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 flush  in  1  synchronous discard of all stored words.
REQ-009 wr_valid  in  1  producer offers wr_data.
REQ-010 wr_ready  out  1  FIFO can accept a word this cycle.
REQ-011 wr_data  in  WIDTH  write word.
REQ-012 rd_valid  out  1  rd_data holds the oldest stored word.
REQ-013 rd_ready  in  1  consumer takes rd_data.
REQ-014 rd_data  out  WIDTH  head word, first-word-fall-through.
REQ-015 count  out  CW  current occupancy, 0..DEPTH.
REQ-016 almost_full  out  1  count >= AF_LEVEL.
REQ-017 almost_empty  out  1  count <= AE_LEVEL.
REQ-018 high_water  out  CW  maximum count reached since last rst or hw_clear.
REQ-019 hw_clear  in  1  reload high_water with current count.

Function
REQ-020 Push SHALL occur when wr_valid && wr_ready; pop SHALL occur when rd_valid && rd_ready.
REQ-021 wr_ready SHALL equal (count < DEPTH), combinational from registered count; a push is refused when full even if a pop occurs the same cycle.
REQ-022 rd_valid SHALL equal (count != 0); rd_data SHALL be storage[rd_ptr] with no extra cycle of latency.
REQ-023 A word pushed in cycle N SHALL be visible on rd_data with rd_valid high in cycle N+1 when the FIFO was empty.
REQ-024 rd_data while rd_valid is low is don't-care; no pop SHALL occur when empty.
REQ-025 wr_ptr and rd_ptr SHALL range 0..DEPTH-1 and wrap DEPTH-1 -> 0 for any DEPTH.
REQ-026 count next = count + push - pop; simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-027 Words SHALL leave in exact push order with no loss or duplication across any number of pointer wraps.
REQ-028 flush SHALL, on the next edge, set wr_ptr=rd_ptr=0 and count=0; any push or pop in the flush cycle SHALL be discarded.
REQ-029 high_water next = max(high_water, count next) each cycle; flush SHALL NOT clear high_water.
REQ-030 hw_clear SHALL load high_water with count next; rst takes priority over flush, flush over hw_clear and push/pop.
REQ-031 almost_full and almost_empty SHALL be combinational from registered count.

Reset
REQ-032 On rst: wr_ptr=rd_ptr=0, count=0, high_water=0; thus wr_ready=1, rd_valid=0, almost_full=0, almost_empty=1 from the next cycle.
REQ-033 rst mid-operation SHALL discard all stored words; storage contents need not be cleared.

Verification
REQ-034 DEPTH=5: 5 pushes of 0x11..0x15 with rd_ready=0 -> count=5, wr_ready=0; 6th push refused; then 5 pops return 0x11..0x15 in order.
REQ-035 Empty FIFO, push 0xA5 at cycle N -> rd_valid=1, rd_data=0xA5 at N+1; pop at N+1 -> rd_valid=0, count=0 at N+2.
REQ-036 count=3, push and pop in same cycle for 20 cycles with incrementing data -> count stays 3, output order matches input, pointers wrap cleanly.
REQ-037 DEPTH=16, AF_LEVEL=14, AE_LEVEL=2: fill to 14 -> almost_full=1 at count 14, almost_empty=0 from count 3; high_water=14.
REQ-038 count=7, flush with wr_valid=1 and rd_ready=1 -> next cycle count=0, rd_valid=0, high_water unchanged; hw_clear then -> high_water=0.
REQ-039 Random push/pop for 10000 cycles against a reference queue -> data order, count, wr_ready, rd_valid match every cycle.

Source files
------------

// File: rtl/param_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : param_fifo
//  Purpose  : Parameterised first-word-fall-through FIFO with occupancy,
//             almost-full/empty flags and a resettable high-water mark.
//  Revision : 1.0 - initial release
// ============================================================================
module param_fifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    high_water,
    input  logic             hw_clear
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] C_LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    high_water_q, high_water_d;
    logic             w_push;
    logic             w_pop;

    assign wr_ready     = (count_q < CW'(DEPTH));
    assign rd_valid     = (count_q != '0);
    assign rd_data      = mem_q[rd_ptr_q];
    assign count        = count_q;
    assign high_water   = high_water_q;
    assign almost_full  = (count_q >= CW'(AF_LEVEL));
    assign almost_empty = (count_q <= CW'(AE_LEVEL));

    assign w_push = wr_valid && wr_ready;
    assign w_pop  = rd_valid && rd_ready;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        high_water_d = high_water_q;
        if (flush) begin
            // Flush drops everything but keeps the high-water history.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) begin
                wr_ptr_d = (wr_ptr_q == C_LAST) ? '0 : wr_ptr_q + PW'(1);
            end
            if (w_pop) begin
                rd_ptr_d = (rd_ptr_q == C_LAST) ? '0 : rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(w_push) - CW'(w_pop);
            if (hw_clear) begin
                high_water_d = count_d;
            end else if (count_d > high_water_q) begin
                high_water_d = count_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            high_water_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            high_water_q <= high_water_d;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_push && !flush && !rst) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_param_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_param_fifo
//  Purpose  : Self-checking bench for param_fifo (DEPTH=16 and DEPTH=5).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_param_fifo;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: default parameters
    logic       a_flush = 0, a_wr_valid = 0, a_rd_ready = 0, a_hw_clear = 0;
    logic [7:0] a_wr_data = 0;
    logic       a_wr_ready, a_rd_valid, a_almost_full, a_almost_empty;
    logic [7:0] a_rd_data;
    logic [4:0] a_count, a_high_water;

    // Instance B: non-power-of-two depth
    logic       b_flush = 0, b_wr_valid = 0, b_rd_ready = 0, b_hw_clear = 0;
    logic [7:0] b_wr_data = 0;
    logic       b_wr_ready, b_rd_valid, b_almost_full, b_almost_empty;
    logic [7:0] b_rd_data;
    logic [2:0] b_count, b_high_water;

    param_fifo #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)) dut_a (
        .clk(clk), .rst(rst), .flush(a_flush),
        .wr_valid(a_wr_valid), .wr_ready(a_wr_ready), .wr_data(a_wr_data),
        .rd_valid(a_rd_valid), .rd_ready(a_rd_ready), .rd_data(a_rd_data),
        .count(a_count), .almost_full(a_almost_full), .almost_empty(a_almost_empty),
        .high_water(a_high_water), .hw_clear(a_hw_clear)
    );

    param_fifo #(.WIDTH(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) dut_b (
        .clk(clk), .rst(rst), .flush(b_flush),
        .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .wr_data(b_wr_data),
        .rd_valid(b_rd_valid), .rd_ready(b_rd_ready), .rd_data(b_rd_data),
        .count(b_count), .almost_full(b_almost_full), .almost_empty(b_almost_empty),
        .high_water(b_high_water), .hw_clear(b_hw_clear)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 12;
        if (a_count !== 5'd0)        begin failures++; $display("FAIL reset_a_count got=%0d exp=0", a_count); end
        if (a_wr_ready !== 1'b1)     begin failures++; $display("FAIL reset_a_wr_ready got=%b exp=1", a_wr_ready); end
        if (a_rd_valid !== 1'b0)     begin failures++; $display("FAIL reset_a_rd_valid got=%b exp=0", a_rd_valid); end
        if (a_almost_full !== 1'b0)  begin failures++; $display("FAIL reset_a_almost_full got=%b exp=0", a_almost_full); end
        if (a_almost_empty !== 1'b1) begin failures++; $display("FAIL reset_a_almost_empty got=%b exp=1", a_almost_empty); end
        if (a_high_water !== 5'd0)   begin failures++; $display("FAIL reset_a_high_water got=%0d exp=0", a_high_water); end
        if (b_count !== 3'd0)        begin failures++; $display("FAIL reset_b_count got=%0d exp=0", b_count); end
        if (b_wr_ready !== 1'b1)     begin failures++; $display("FAIL reset_b_wr_ready got=%b exp=1", b_wr_ready); end
        if (b_rd_valid !== 1'b0)     begin failures++; $display("FAIL reset_b_rd_valid got=%b exp=0", b_rd_valid); end
        if (b_almost_full !== 1'b0)  begin failures++; $display("FAIL reset_b_almost_full got=%b exp=0", b_almost_full); end
        if (b_almost_empty !== 1'b1) begin failures++; $display("FAIL reset_b_almost_empty got=%b exp=1", b_almost_empty); end
        if (b_high_water !== 3'd0)   begin failures++; $display("FAIL reset_b_high_water got=%0d exp=0", b_high_water); end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 5; i++) begin
            b_wr_valid = 1'b1;
            b_wr_data  = 8'h11 + 8'(i);
            cycle();
        end
        checks += 2;
        if (b_count !== 3'd5)    begin failures++; $display("FAIL full_count got=%0d exp=5", b_count); end
        if (b_wr_ready !== 1'b0) begin failures++; $display("FAIL full_wr_ready got=%b exp=0", b_wr_ready); end
        b_wr_data = 8'h99;
        cycle();
        b_wr_valid = 1'b0;
        checks++;
        if (b_count !== 3'd5) begin failures++; $display("FAIL refused_push_count got=%0d exp=5", b_count); end
        b_rd_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (b_rd_valid !== 1'b1 || b_rd_data !== 8'h11 + 8'(i)) begin
                failures++;
                $display("FAIL drain_data[%0d] got valid=%b data=%h exp valid=1 data=%h", i, b_rd_valid, b_rd_data, 8'h11 + 8'(i));
            end
            cycle();
        end
        b_rd_ready = 1'b0;
        checks++;
        if (b_count !== 3'd0 || b_rd_valid !== 1'b0) begin
            failures++; $display("FAIL drained_empty got count=%0d rd_valid=%b exp 0/0", b_count, b_rd_valid);
        end
    endtask

    task automatic test_fall_through();
        a_wr_valid = 1'b1;
        a_wr_data  = 8'hA5;
        cycle();
        a_wr_valid = 1'b0;
        checks++;
        if (a_rd_valid !== 1'b1 || a_rd_data !== 8'hA5 || a_count !== 5'd1) begin
            failures++; $display("FAIL fwft got valid=%b data=%h count=%0d exp 1/a5/1", a_rd_valid, a_rd_data, a_count);
        end
        a_rd_ready = 1'b1;
        cycle();
        a_rd_ready = 1'b0;
        checks++;
        if (a_rd_valid !== 1'b0 || a_count !== 5'd0) begin
            failures++; $display("FAIL fwft_pop got valid=%b count=%0d exp 0/0", a_rd_valid, a_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] next_in  = 8'h00;
        logic [7:0] next_out = 8'h00;
        a_wr_valid = 1'b1;
        repeat (3) begin
            a_wr_data = next_in;
            next_in++;
            cycle();
        end
        a_rd_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a_wr_data = next_in;
            next_in++;
            checks++;
            if (a_rd_data !== next_out) begin
                failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, a_rd_data, next_out);
            end
            next_out++;
            cycle();
            checks++;
            if (a_count !== 5'd3) begin
                failures++; $display("FAIL b2b_count[%0d] got=%0d exp=3", i, a_count);
            end
        end
        a_wr_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (a_rd_valid !== 1'b1 || a_rd_data !== next_out) begin
                failures++; $display("FAIL b2b_tail[%0d] got valid=%b data=%h exp=%h", i, a_rd_valid, a_rd_data, next_out);
            end
            next_out++;
            cycle();
        end
        a_rd_ready = 1'b0;
        checks++;
        if (a_count !== 5'd0) begin failures++; $display("FAIL b2b_empty got=%0d exp=0", a_count); end
    endtask

    task automatic test_levels();
        a_hw_clear = 1'b1;
        cycle();
        a_hw_clear = 1'b0;
        a_wr_valid = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            a_wr_data = 8'(n);
            cycle();
            checks++;
            if (a_almost_full !== (n >= 14) || a_almost_empty !== (n <= 2) || a_count !== 5'(n)) begin
                failures++;
                $display("FAIL levels[%0d] got af=%b ae=%b count=%0d exp af=%b ae=%b", n, a_almost_full, a_almost_empty, a_count, n >= 14, n <= 2);
            end
        end
        a_wr_valid = 1'b0;
        checks++;
        if (a_high_water !== 5'd14) begin failures++; $display("FAIL levels_hw got=%0d exp=14", a_high_water); end
    endtask

    task automatic test_flush();
        a_rd_ready = 1'b1;
        repeat (7) cycle();
        a_rd_ready = 1'b0;
        checks++;
        if (a_count !== 5'd7) begin failures++; $display("FAIL flush_pre_count got=%0d exp=7", a_count); end
        a_flush    = 1'b1;
        a_wr_valid = 1'b1;
        a_rd_ready = 1'b1;
        a_wr_data  = 8'h77;
        cycle();
        a_flush    = 1'b0;
        a_wr_valid = 1'b0;
        a_rd_ready = 1'b0;
        checks++;
        if (a_count !== 5'd0 || a_rd_valid !== 1'b0 || a_high_water !== 5'd14) begin
            failures++; $display("FAIL flush got count=%0d rd_valid=%b hw=%0d exp 0/0/14", a_count, a_rd_valid, a_high_water);
        end
        a_hw_clear = 1'b1;
        cycle();
        a_hw_clear = 1'b0;
        checks++;
        if (a_high_water !== 5'd0) begin failures++; $display("FAIL hw_clear got=%0d exp=0", a_high_water); end
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        int         hw = 0;
        int         sz;
        logic       wv, rr, fl, hc, push, pop;
        logic [7:0] wd;
        // Leave words behind, then reset must discard them.
        b_wr_valid = 1'b1;
        repeat (3) cycle();
        b_wr_valid = 1'b0;
        do_reset();
        checks++;
        if (b_count !== 3'd0 || b_rd_valid !== 1'b0) begin
            failures++; $display("FAIL mid_reset got count=%0d rd_valid=%b exp 0/0", b_count, b_rd_valid);
        end
        for (int c = 0; c < 10000; c++) begin
            sz = q.size();
            checks++;
            if (b_count !== 3'(sz) || b_wr_ready !== (sz < 5) || b_rd_valid !== (sz != 0) ||
                b_almost_full !== (sz >= 4) || b_almost_empty !== (sz <= 1) || b_high_water !== 3'(hw) ||
                (sz != 0 && b_rd_data !== q[0])) begin
                failures++;
                $display("FAIL random[%0d] got count=%0d wr_ready=%b rd_valid=%b data=%h af=%b ae=%b hw=%0d exp count=%0d head=%h hw=%0d",
                         c, b_count, b_wr_ready, b_rd_valid, b_rd_data, b_almost_full, b_almost_empty, b_high_water,
                         sz, (sz != 0) ? q[0] : 8'h00, hw);
            end
            wv = 1'($urandom_range(0, 1));
            rr = 1'($urandom_range(0, 1));
            fl = ($urandom_range(0, 63) == 0);
            hc = ($urandom_range(0, 31) == 0);
            wd = 8'($urandom);
            b_wr_valid = wv; b_rd_ready = rr; b_flush = fl; b_hw_clear = hc; b_wr_data = wd;
            push = wv && (sz < 5);
            pop  = rr && (sz != 0);
            if (fl) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (push) q.push_back(wd);
                if (hc) hw = q.size();
                else if (q.size() > hw) hw = q.size();
            end
            cycle();
        end
        b_wr_valid = 1'b0; b_rd_ready = 1'b0; b_flush = 1'b0; b_hw_clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_fall_through();
        test_back_to_back();
        test_levels();
        test_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
